// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request arbiter: cache line geometry, L2 request packet
// layout, arbitration source indices and the one-hot to index helper.
package l2_request_arbiter_pkg;

    localparam int unsigned CACHE_LINE_BYTES        = 64;
    localparam int unsigned CACHE_LINE_BITS         = CACHE_LINE_BYTES * 8;
    localparam int unsigned CACHE_LINE_OFFSET_WIDTH = $clog2(CACHE_LINE_BYTES);
    localparam int unsigned ADDR_WIDTH              = 32;
    localparam int unsigned L1_MISS_ENTRIES         = 4;
    localparam int unsigned CORE_ID_WIDTH           = 4;

    localparam int unsigned L2_ARB_MAX_OUTSTANDING  = 8;
    localparam int unsigned ARB_NUM_SRC             = 3;

    typedef logic [ADDR_WIDTH-CACHE_LINE_OFFSET_WIDTH-1:0] cache_line_index_t;
    typedef logic [CACHE_LINE_BITS-1:0]                    cache_line_data_t;
    typedef logic [$clog2(L1_MISS_ENTRIES)-1:0]            l1_miss_entry_idx_t;
    typedef logic [CORE_ID_WIDTH-1:0]                      core_id_t;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_IINVALIDATE = 3'd3,
        L2REQ_DINVALIDATE = 3'd4,
        L2REQ_LOAD_SYNC   = 3'd5,
        L2REQ_STORE_SYNC  = 3'd6
    } l2req_packet_type_t;

    typedef enum logic {
        CT_ICACHE = 1'b0,
        CT_DCACHE = 1'b1
    } cache_type_t;

    typedef struct packed {
        core_id_t                    core;
        l1_miss_entry_idx_t          id;
        l2req_packet_type_t          packet_type;
        cache_line_index_t           address;
        cache_line_data_t            data;
        logic [CACHE_LINE_BYTES-1:0] store_mask;
        cache_type_t                 cache_type;
    } l2req_packet_t;

    typedef enum logic [1:0] {
        ARB_SRC_DCACHE = 2'd0,
        ARB_SRC_ICACHE = 2'd1,
        ARB_SRC_STORE  = 2'd2
    } arb_src_t;

    function automatic arb_src_t oh_to_idx(input logic [ARB_NUM_SRC-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(ARB_NUM_SRC); i++) begin
            if (oh[i]) idx = idx | 2'(i);
        end
        return arb_src_t'(idx);
    endfunction

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Combinational round-robin selector: searches from last_grant+1 upwards, wrapping,
// and returns a one-hot grant (all-zero when nothing requests).
module rr_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 3,
    localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic [NUM_REQUESTERS-1:0] i_request,
    input  logic [IDX_W-1:0]          i_last_grant,
    output logic [NUM_REQUESTERS-1:0] o_grant
);

    always_comb begin : p_select
        logic [IDX_W-1:0] v_idx;
        logic             v_found;
        o_grant = '0;
        v_found = 1'b0;
        v_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            v_idx = IDX_W'((32'(i_last_grant) + k) % NUM_REQUESTERS);
            if (!v_found && i_request[v_idx]) begin
                o_grant[v_idx] = 1'b1;
                v_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbitrates dcache, icache and store-queue requests onto the single L2 request port,
// with round-robin fairness, a hold lock while L2 back-pressures, and response credits.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter core_id_t    CORE_ID         = '0,
    parameter int unsigned MAX_OUTSTANDING = L2_ARB_MAX_OUTSTANDING
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic                                   dcache_dequeue_ready,
    input  cache_line_index_t                      dcache_dequeue_adr,
    input  l1_miss_entry_idx_t                     dcache_dequeue_idx,
    input  logic                                   dcache_dequeue_sync,
    output logic                                   dcache_dequeue_ack,

    input  logic                                   icache_dequeue_ready,
    input  cache_line_index_t                      icache_dequeue_adr,
    input  l1_miss_entry_idx_t                     icache_dequeue_idx,
    output logic                                   icache_dequeue_ack,

    input  logic                                   sq_dequeue_ready,
    input  cache_line_index_t                      sq_dequeue_adr,
    input  l1_miss_entry_idx_t                     sq_dequeue_idx,
    input  cache_line_data_t                       sq_dequeue_data,
    input  logic [CACHE_LINE_BYTES-1:0]            sq_dequeue_mask,
    input  logic                                   sq_dequeue_flush,
    input  logic                                   sq_dequeue_sync,
    input  logic                                   sq_dequeue_iinvalidate,
    input  logic                                   sq_dequeue_dinvalidate,
    output logic                                   storebuf_dequeue_ack,

    input  logic                                   l2_ready,
    output logic                                   l2i_request_valid,
    output l2req_packet_t                          l2i_request,

    input  logic                                   rsp_retire,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   arb_outstanding,
    output logic                                   arb_credit_stall
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ARB_NUM_SRC-1:0] w_ready;
    logic [ARB_NUM_SRC-1:0] w_rr_grant;
    arb_src_t               w_rr_src;
    arb_src_t               w_sel_src;
    l2req_packet_t          w_src_pkt;
    l2req_packet_t          w_pkt;
    logic                   w_credit_ok;
    logic                   w_valid;
    logic                   w_accept;
    logic                   w_retire_ok;

    arb_src_t               r_last_grant;
    logic                   r_locked;
    arb_src_t               r_lock_src;
    l2req_packet_t          r_lock_pkt;
    logic [CNT_W-1:0]       r_outstanding;

    assign w_ready = {sq_dequeue_ready, icache_dequeue_ready, dcache_dequeue_ready};

    rr_arbiter #(
        .NUM_REQUESTERS (ARB_NUM_SRC)
    ) u_rr_arbiter (
        .i_request    (w_ready),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant)
    );

    assign w_rr_src    = oh_to_idx(w_rr_grant);
    assign w_credit_ok = r_outstanding < CNT_W'(MAX_OUTSTANDING);
    // A held lock already owns its credit, so it stays presented regardless of the count.
    assign w_valid     = !reset && (r_locked || ((|w_ready) && w_credit_ok));
    assign w_sel_src   = r_locked ? r_lock_src : w_rr_src;
    assign w_accept    = w_valid && l2_ready;
    assign w_retire_ok = rsp_retire && (r_outstanding != '0);

    always_comb begin
        w_src_pkt      = '0;
        w_src_pkt.core = CORE_ID;
        case (w_rr_src)
            ARB_SRC_DCACHE: begin
                w_src_pkt.id          = dcache_dequeue_idx;
                w_src_pkt.address     = dcache_dequeue_adr;
                w_src_pkt.packet_type = dcache_dequeue_sync ? L2REQ_LOAD_SYNC : L2REQ_LOAD;
                w_src_pkt.cache_type  = CT_DCACHE;
            end
            ARB_SRC_ICACHE: begin
                w_src_pkt.id          = icache_dequeue_idx;
                w_src_pkt.address     = icache_dequeue_adr;
                w_src_pkt.packet_type = L2REQ_LOAD;
                w_src_pkt.cache_type  = CT_ICACHE;
            end
            ARB_SRC_STORE: begin
                w_src_pkt.id          = sq_dequeue_idx;
                w_src_pkt.address     = sq_dequeue_adr;
                w_src_pkt.data        = sq_dequeue_data;
                w_src_pkt.store_mask  = sq_dequeue_mask;
                w_src_pkt.cache_type  = CT_DCACHE;
                if (sq_dequeue_flush) begin
                    w_src_pkt.packet_type = L2REQ_FLUSH;
                end else if (sq_dequeue_sync) begin
                    w_src_pkt.packet_type = L2REQ_STORE_SYNC;
                end else if (sq_dequeue_iinvalidate) begin
                    w_src_pkt.packet_type = L2REQ_IINVALIDATE;
                end else if (sq_dequeue_dinvalidate) begin
                    w_src_pkt.packet_type = L2REQ_DINVALIDATE;
                end else begin
                    w_src_pkt.packet_type = L2REQ_STORE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_pkt      = '0;
        w_pkt.core = CORE_ID;
        if (w_valid) begin
            w_pkt = r_locked ? r_lock_pkt : w_src_pkt;
        end
    end

    assign l2i_request_valid    = w_valid;
    assign l2i_request          = w_pkt;
    assign dcache_dequeue_ack   = w_accept && (w_sel_src == ARB_SRC_DCACHE);
    assign icache_dequeue_ack   = w_accept && (w_sel_src == ARB_SRC_ICACHE);
    assign storebuf_dequeue_ack = w_accept && (w_sel_src == ARB_SRC_STORE);
    assign arb_outstanding      = r_outstanding;
    assign arb_credit_stall     = !reset && !r_locked && (|w_ready) &&
                                  (r_outstanding == CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant  <= ARB_SRC_STORE;
            r_locked      <= 1'b0;
            r_lock_src    <= ARB_SRC_DCACHE;
            r_lock_pkt    <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_sel_src;
                r_locked     <= 1'b0;
            end else if (w_valid && !r_locked) begin
                // Snapshot the packet so the held request cannot change under back-pressure.
                r_locked   <= 1'b1;
                r_lock_src <= w_sel_src;
                r_lock_pkt <= w_src_pkt;
            end
            if (w_accept && !w_retire_ok) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_accept && w_retire_ok) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
        end
    end

    a_lock_source_held: assert property (@(posedge clk) disable iff (reset)
        r_locked |-> w_ready[r_lock_src]);

    a_retire_underflow: assert property (@(posedge clk) disable iff (reset)
        rsp_retire |-> (r_outstanding != '0));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        r_outstanding <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- CORE_ID, 0, value driven into l2i_request.core.
- MAX_OUTSTANDING, 8, cap on accepted requests awaiting a response.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- dcache_dequeue_ready/adr/idx/sync  in  1/cache_line_index_t/l1_miss_entry_idx_t/1  dcache load miss source.
- dcache_dequeue_ack  out  1  dcache request accepted.
- icache_dequeue_ready/adr/idx  in  1/cache_line_index_t/l1_miss_entry_idx_t  icache load miss source.
- icache_dequeue_ack  out  1  icache request accepted.
- sq_dequeue_ready/adr/idx  in  1/cache_line_index_t/l1_miss_entry_idx_t  store queue source.
- sq_dequeue_data/mask  in  cache_line_data_t/CACHE_LINE_BYTES  store payload.
- sq_dequeue_flush/sync/iinvalidate/dinvalidate  in  1 each  store queue operation type.
- storebuf_dequeue_ack  out  1  store request accepted.
- l2_ready  in  1  L2 accepts the presented request this cycle.
- l2i_request_valid  out  1  request presented.
- l2i_request  out  l2req_packet_t  request packet.
- rsp_retire  in  1  one L2 response addressed to CORE_ID is retired this cycle.
- arb_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted requests without a response.
- arb_credit_stall  out  1  a source is ready but credits are exhausted.

Function
REQ-003 Source indices SHALL be 0=dcache, 1=icache, 2=store queue.
REQ-004 Grant SHALL be round-robin among ready sources: search starts at (last_grant+1) mod 3 and wraps.
REQ-005 l2i_request_valid SHALL depend only on source ready signals and internal registers. It SHALL never depend combinationally on l2_ready.
REQ-006 Acceptance SHALL be l2i_request_valid && l2_ready. Exactly the granted source's ack SHALL assert that cycle. All other acks SHALL be 0.
REQ-007 On acceptance, last_grant SHALL update to the granted index on the next edge.
REQ-008 Lock rule:
- When valid && !l2_ready, a lock SHALL be set to the granted source.
- While locked, the same source SHALL be presented with identical packet contents, regardless of other ready sources.
- The lock SHALL clear on acceptance.
REQ-009 A locked source SHALL keep ready asserted until acked. A violation SHALL raise a simulation assertion.
REQ-010 Credits:
- An unlocked request SHALL be presented only when arb_outstanding < MAX_OUTSTANDING.
- A locked request SHALL stay presented, because its credit was already reserved.
REQ-011 arb_outstanding update per cycle:
- +1 on acceptance.
- -1 on rsp_retire.
- Unchanged when both occur in the same cycle.
REQ-012 rsp_retire with arb_outstanding==0 SHALL be an assertion failure with the counter held at 0. Exceeding MAX_OUTSTANDING SHALL be impossible.
REQ-013 arb_credit_stall SHALL be 1 when no lock is held, any source is ready, and arb_outstanding==MAX_OUTSTANDING.
REQ-014 Packet encoding:
- core=CORE_ID always.
- dcache: packet_type=L2REQ_LOAD_SYNC if sync else L2REQ_LOAD, cache_type=CT_DCACHE.
- icache: packet_type=L2REQ_LOAD, cache_type=CT_ICACHE.
- store: packet_type priority is flush→L2REQ_FLUSH, sync→L2REQ_STORE_SYNC, iinvalidate→L2REQ_IINVALIDATE, dinvalidate→L2REQ_DINVALIDATE, else L2REQ_STORE. Data and store_mask SHALL be from sq. cache_type=CT_DCACHE.
- id and adress SHALL come from the granted source.
- Fields unused by the granted operation SHALL be 0.
REQ-015 When no request is presented, l2i_request SHALL be all-zero except core.
REQ-016 Latency: a ready source with a free credit and no competing lock SHALL be presented in the same cycle. Each source SHALL be accepted within 3 acceptances of becoming ready.

Reset
REQ-017 While reset is asserted:
- last_grant=2, so dcache has first priority.
- Lock cleared.
- arb_outstanding=0.
- l2i_request_valid=0, all acks=0, arb_credit_stall=0.
REQ-018 Reset asserted mid-handshake SHALL drop the lock and pending request immediately. No ack SHALL issue during reset.

Structure
REQ-019 The MAX_OUTSTANDING default and a source index enum (ARB_SRC_DCACHE/ICACHE/STORE) SHALL be added to the defines package. Packet types SHALL reuse existing package typedefs.
REQ-020 The round-robin selection SHALL be one sub-module, rr_arbiter, parameterized by NUM_REQUESTERS, producing a one-hot grant. Index conversion SHALL use existing oh_to_idx.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- All three ready, l2_ready=1 continuously, after reset → acks in order dcache, icache, store, dcache.
- icache ready, l2_ready=0 for 4 cycles, dcache asserts at cycle 2 → icache packet held stable for 4 cycles, icache acked on cycle 5, dcache next.
- MAX_OUTSTANDING=2, dcache ready, 2 acceptances → valid=0, arb_credit_stall=1; one rsp_retire → request re-presented next cycle.
- Acceptance and rsp_retire in the same cycle with outstanding=1 → outstanding stays 1.
- sq ready with flush=1 and sync=1 → packet_type=L2REQ_FLUSH, storebuf_dequeue_ack on l2_ready, other acks 0.
- reset asserted while locked on store with outstanding=3 → valid=0 and outstanding=0 immediately; after release, dcache granted first.
